btn_conditioner: RTL and testbench

Converts one raw, bouncing, asynchronous push-button input into clean single-cycle event pulses and a debounced level for the game control logic. It sits directly upstream of the reset-to-one state flops and the spin/stop control that consume button events. It performs synchronisation, a debounce state machine, edge pulses and optional hold-to-repeat.

---
 rtl/btn_cond_pkg.sv | 26 ++
 rtl/btn_conditioner_if.sv | 24 ++
 rtl/btn_sync.sv | 22 ++
 rtl/btn_conditioner.sv | 163 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 20;
  localparam int unsigned DEF_REPEAT_CYCLES   = 8;

  // One spare bit above the largest count so saturation never aliases a target value.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw button in, conditioned events out.
interface btn_conditioner_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a single asynchronous input, reset to 0.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/btn_conditioner.sv
// Debounced push-button: synchroniser, debounce FSM, press/release pulses.
// Optional hold-to-repeat enabled by defining BTN_COND_AUTO_REPEAT_EN.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  btn_conditioner_if.slave    bus
);
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s;

  btn_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (s)
  );

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rpt_pulse_q, rpt_pulse_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef BTN_COND_AUTO_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          rpt_phase_q, rpt_phase_d;

  // Hold count runs only in PRESSED; RELEASE_WAIT leaves it frozen.
  always_comb begin
    hold_d      = hold_q;
    rpt_d       = rpt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_pulse_d = 1'b0;
    if (press_d || rel_d) begin
      hold_d      = '0;
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
    end else if (state_q == PRESSED) begin
      if (!rpt_phase_q) begin
        if (hold_q == HOLD_LAST) begin
          rpt_pulse_d = 1'b1;
          rpt_phase_d = 1'b1;
          rpt_d       = '0;
        end else begin
          hold_d = sat_inc(hold_q);
        end
      end else if (rpt_q == RPT_LAST) begin
        rpt_pulse_d = 1'b1;
        rpt_d       = '0;
      end else begin
        rpt_d = sat_inc(rpt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  always_comb rpt_pulse_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      rpt_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      rpt_pulse_q <= rpt_pulse_d;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.repeat_pulse  = rpt_pulse_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: run-length reference model plus directed literal checks.
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btn_conditioner_if bif ();
  btn_conditioner_if bif1 ();
  assign bif1.btn_in = bif.btn_in;

  btn_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif1.slave)
  );

  // Model: the FSM sees btn_in two edges late; a level flips once D+1
  // consecutive samples disagree with it. Repeats count edges spent pressed.
  typedef struct {
    bit b1, b2, lvl;
    int run, n;
    bit press, rel, rep;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input bit btn, input bit rst_n, input int d);
    mdl_t r;
    bit   s;
    bit   in_pressed;
    r = m;
    r.press = 0; r.rel = 0; r.rep = 0;
    if (!rst_n) begin
      r.b1 = 0; r.b2 = 0; r.lvl = 0; r.run = 0; r.n = 0;
      return r;
    end
    s    = m.b2;
    r.b2 = m.b1;
    r.b1 = btn;
    in_pressed = m.lvl && (m.run == 0);
    r.run = (s != m.lvl) ? m.run + 1 : 0;
    if (r.run == d + 1) begin
      r.lvl = !m.lvl;
      r.run = 0;
      if (r.lvl) begin r.press = 1; r.n = 0; end
      else r.rel = 1;
    end
`ifdef BTN_COND_AUTO_REPEAT_EN
    if (in_pressed) begin
      r.n = m.n + 1;
      if (r.n == 20 || (r.n > 20 && (r.n - 20) % 8 == 0)) r.rep = 1;
    end
`else
    if (in_pressed) r.n = m.n + 1;
`endif
    return r;
  endfunction

  int compared = 0;
  int mismatched = 0;
  int n_press4 = 0;
  int n_rel4 = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  initial begin
    mdl_t m4, m1;
    bit   bs, rs;
    m4 = '{default: 0};
    m1 = '{default: 0};
    forever begin
      @(posedge clk);
      bs = bif.btn_in;
      rs = reset;
      #1;
      m4 = step(m4, bs, rs, 4);
      m1 = step(m1, bs, rs, 1);
      chk("d4_level",   bif.btn_level,     m4.lvl);
      chk("d4_press",   bif.press_pulse,   m4.press);
      chk("d4_release", bif.release_pulse, m4.rel);
      chk("d4_repeat",  bif.repeat_pulse,  m4.rep);
      chk("d1_level",   bif1.btn_level,     m1.lvl);
      chk("d1_press",   bif1.press_pulse,   m1.press);
      chk("d1_release", bif1.release_pulse, m1.rel);
      chk("d1_repeat",  bif1.repeat_pulse,  m1.rep);
      if (bif.press_pulse === 1'b1) n_press4++;
      if (bif.release_pulse === 1'b1) n_rel4++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_p, base_r;
    reset = 1'b0;
    bif.btn_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_level",   bif.btn_level,     1'b0);
    chk("rst_press",   bif.press_pulse,   1'b0);
    chk("rst_release", bif.release_pulse, 1'b0);
    chk("rst_repeat",  bif.repeat_pulse,  1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press: high before edge 0, held until edge 30
    bif.btn_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("clean_e5_press", bif.press_pulse, 1'b0);
    chk("clean_e5_level", bif.btn_level,   1'b0);
    @(posedge clk); #1;
    chk("clean_e6_press", bif.press_pulse, 1'b1);
    chk("clean_e6_level", bif.btn_level,   1'b1);
    @(posedge clk); #1;
    chk("clean_e7_press", bif.press_pulse, 1'b0);
    repeat (22) @(posedge clk);
    @(negedge clk) bif.btn_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("clean_e35_level", bif.btn_level,     1'b1);
    chk("clean_e35_rel",   bif.release_pulse, 1'b0);
    @(posedge clk); #1;
    chk("clean_e36_rel",   bif.release_pulse, 1'b1);
    chk("clean_e36_level", bif.btn_level,     1'b0);
    @(posedge clk); #1;
    chk("clean_e37_rel",   bif.release_pulse, 1'b0);

    // Press bounce: 2-cycle toggles never reach the debounce count
    repeat (10) @(negedge clk);
    base_p = n_press4;
    for (int i = 0; i < 6; i++) begin
      bif.btn_in = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    bif.btn_in = 1'b0;
    repeat (10) @(negedge clk);
    chk_int("bounce_presses", n_press4 - base_p, 0);
    chk("bounce_level", bif.btn_level, 1'b0);

    // Release bounce: 3 low cycles while pressed
    bif.btn_in = 1'b1;
    repeat (12) @(negedge clk);
    base_p = n_press4;
    base_r = n_rel4;
    bif.btn_in = 1'b0;
    repeat (3) @(negedge clk);
    bif.btn_in = 1'b1;
    repeat (10) @(negedge clk);
    chk_int("relbounce_releases", n_rel4 - base_r, 0);
    chk_int("relbounce_presses",  n_press4 - base_p, 0);
    chk("relbounce_level", bif.btn_level, 1'b1);

    // Reset while held, then fresh press after deassertion
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_level", bif.btn_level,   1'b0);
    chk("midrst_press", bif.press_pulse, 1'b0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_r5_press", bif.press_pulse, 1'b0);
    @(posedge clk); #1;
    chk("midrst_r6_press", bif.press_pulse, 1'b1);
    chk("midrst_r6_level", bif.btn_level,   1'b1);
    @(negedge clk) bif.btn_in = 1'b0;
    repeat (12) @(negedge clk);

    // Two-cycle glitch on the DEBOUNCE_CYCLES=1 instance
    bif.btn_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) bif.btn_in = 1'b0;
    @(posedge clk); #1;
    chk("d1_e2_press", bif1.press_pulse, 1'b0);
    @(posedge clk); #1;
    chk("d1_e3_press", bif1.press_pulse, 1'b1);
    chk("d1_e3_level", bif1.btn_level,   1'b1);
    @(posedge clk); #1;
    chk("d1_e4_press", bif1.press_pulse,   1'b0);
    chk("d1_e4_rel",   bif1.release_pulse, 1'b0);
    @(posedge clk); #1;
    chk("d1_e5_rel",   bif1.release_pulse, 1'b1);
    chk("d1_e5_level", bif1.btn_level,     1'b0);
    chk("d4_glitch_level", bif.btn_level,  1'b0);

    // Random segments with occasional reset pulses
    for (int seg = 0; seg < 400; seg++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) bif.btn_in = ~bif.btn_in;
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(20, 40)) @(negedge clk);
      else
        repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    bif.btn_in = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
